// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared types and helpers for the branch resolve unit:
//   - br_funct3_e : conditional-branch funct3 encodings
//   - BHT_*       : 2-bit bimodal counter states
//   - bht_next()  : saturating counter step
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  // Saturating 2-bit counter: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
    end else begin
      return (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// -----------------------------------------------------------------------------
// bht_2bit
// Array of 2-bit saturating counters forming a bimodal branch history table.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset (all entries -> WNT)
//   rd_idx_i         asynchronous read index (fetch lookup)
//   rd_taken_o       MSB of the addressed counter (predict taken)
//   upd_idx_i        update index (execute resolve)
//   upd_taken_i      resolved direction used to step the counter
//   upd_en_i         write enable; the new value lands at the next rising edge
// A read and update to the same index in one cycle returns the old value.
// -----------------------------------------------------------------------------
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_en_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en_i) begin
      ctr_d[upd_idx_i] = bht_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_WNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // No bypass from the update path: fetch sees the registered state only.
  assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves execute-stage conditional branches against the comparator flags,
// detects mispredicts versus the carried fetch prediction, and issues a
// registered one-cycle flush with the fetch restart PC. Owns a bimodal BHT
// read at fetch and trained at execute.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   pc_f_i               fetch PC for prediction lookup
//   pred_taken_f_o       combinational prediction for pc_f_i
//   br_valid_x_i         execute stage holds a conditional branch
//   funct3_x_i           branch funct3
//   pc_x_i, target_x_i   branch PC and computed target
//   pred_taken_x_i       prediction carried with the branch
//   br_unsign_o          comparator select: 1 = unsigned compare
//   br_less_i/equal_i    comparator flags
//   flush_o              one-cycle pulse killing younger stages
//   redirect_pc_o        restart PC, valid while flush_o is high
//   illegal_br_o         one-cycle pulse for funct3 010/011
// Optional (macro BRU_PERF_CNT_EN):
//   br_cnt_o             count of resolved legal branches
//   mispred_cnt_o        count of mispredicts
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_f_i,
  output logic        pred_taken_f_o,
  input  logic        br_valid_x_i,
  input  logic [2:0]  funct3_x_i,
  input  logic [31:0] pc_x_i,
  input  logic [31:0] target_x_i,
  input  logic        pred_taken_x_i,
  output logic        br_unsign_o,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic        illegal_br_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        illegal_q, illegal_d;

  logic        legal;
  logic        taken;
  logic        eff;
  logic        resolve;
  logic        mispred;

  // Only the index bits of the fetch PC address the table.
  logic        unused_pc_f_bits;
  assign unused_pc_f_bits = ^{pc_f_i[31:IDX_W+2], pc_f_i[1:0]};

  // funct3[1] separates the signed (BLT/BGE) and unsigned (BLTU/BGEU) pairs;
  // for BEQ/BNE the comparator's less flag is don't-care.
  assign br_unsign_o = funct3_x_i[1];

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (br_funct3_e'(funct3_x_i))
      BEQ:       taken = br_equal_i;
      BNE:       taken = !br_equal_i;
      BLT, BLTU: taken = br_less_i;
      BGE, BGEU: taken = !br_less_i;
      default:   legal = 1'b0;
    endcase
  end

  // A branch sitting in execute during the flush cycle is on the wrong path.
  assign eff     = br_valid_x_i & ~flush_q;
  assign resolve = eff & legal;
  assign mispred = resolve & (taken != pred_taken_x_i);

  always_comb begin
    flush_d       = mispred;
    illegal_d     = eff & ~legal;
    redirect_pc_d = redirect_pc_q;
    if (mispred) begin
      redirect_pc_d = taken ? target_x_i : (pc_x_i + 32'd4);
    end
  end

  // ---- resolve -> redirect register boundary ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
      illegal_q     <= 1'b0;
    end else begin
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_pc_q;
  assign illegal_br_o  = illegal_q;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (pc_f_i[IDX_W+1:2]),
    .rd_taken_o  (pred_taken_f_o),
    .upd_idx_i   (pc_x_i[IDX_W+1:2]),
    .upd_taken_i (taken),
    .upd_en_i    (resolve)
  );

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q + {31'd0, resolve};
    mispred_cnt_d = mispred_cnt_q + {31'd0, mispred};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the branch comparator interface.
- Drives the comparator's unsigned-select input and takes back its less and equal flags.
- Decides taken or not-taken for each execute-stage conditional branch, detects mispredicts against the fetch-stage prediction, and issues a registered redirect and flush.
- Holds a bimodal 2-bit branch history table (BHT) that is read at fetch and trained at execute.

Parameters:
- BHT_DEPTH, 64, number of BHT entries; power of two, minimum 4.
- IDX_W, $clog2(BHT_DEPTH), BHT index width; the index is pc[IDX_W+1:2].

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- pc_f_i  in  32  fetch-stage PC for prediction lookup.
- pred_taken_f_o  out  1  prediction for pc_f_i; combinational, equal to BHT[idx][1].
- br_valid_x_i  in  1  execute stage holds a conditional branch.
- funct3_x_i  in  3  branch funct3.
- pc_x_i  in  32  execute-stage branch PC.
- target_x_i  in  32  computed branch target.
- pred_taken_x_i  in  1  prediction carried down the pipe with this branch.
- br_unsign_o  out  1  to comparator: 1 selects unsigned compare.
- br_less_i  in  1  from comparator.
- br_equal_i  in  1  from comparator.
- flush_o  out  1  one-cycle pulse: kill the younger stages.
- redirect_pc_o  out  32  fetch restart PC; valid while flush_o is high.
- illegal_br_o  out  1  one-cycle pulse: funct3 was 010 or 011.

Behaviour:
- br_unsign_o = funct3_x_i[1]. Combinational, and driven even when br_valid_x_i is low.
- Taken decode:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT, 110 BLTU: less
  - 101 BGE, 111 BGEU: !less
  - 010, 011: not taken, illegal_br_o pulses next cycle, BHT is not updated.
- Effective resolve: eff = br_valid_x_i & !flush_o. A branch arriving in the flush cycle is wrong-path and is ignored entirely.
- Mispredict: eff & legal & (taken != pred_taken_x_i). On the next rising edge:
  - flush_o goes to 1.
  - redirect_pc_o = target_x_i if taken, else pc_x_i + 4 (32-bit wrap, so 0xFFFFFFFC+4 = 0).
  - flush_o is high for exactly one cycle. A correct prediction gives flush_o = 0.
- Latency: resolve to flush is one cycle. BHT update is one cycle; the write lands at the same edge.
- BHT entry is a 2-bit saturating counter:
  - taken: increment, saturates at 11.
  - not-taken: decrement, saturates at 00.
  - Only eff & legal branches update.
- Same-cycle read and write at the same index: the fetch read returns the old value. There is no bypass.
- Reset, asynchronous at any time including mid-flush:
  - every BHT entry = 01 (weakly not-taken)
  - flush_o = 0, redirect_pc_o = 0, illegal_br_o = 0
  - counters = 0
- A pending redirect is discarded by reset.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, the unit adds two outputs:
  - br_cnt_o [31:0]: count of eff & legal branches.
  - mispred_cnt_o [31:0]: count of mispredicts.
- Both counters increment at the same edge as the BHT update, wrap at 2^32, and reset to 0.
- When undefined, the ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - enum br_funct3_e: BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111.
  - 2-bit constants: BHT_SNT=00, BHT_WNT=01, BHT_WT=10, BHT_ST=11.
- One sub-module, bht_2bit: parameterised counter array with one asynchronous read port and one synchronous update port (index, taken, enable).
- Decode, mispredict detection and redirect registers live in the top level.

Test Plan:
- Reset, then read any pc_f_i -> pred_taken_f_o = 0. Three taken BEQ (eq=1) at pc 0x100 -> first resolve flushes to the target, entry steps 01→10→11→11, later predictions are 1 with no flush.
- BLTU, pred=0, less=1, target 0x2000 -> br_unsign_o = 1, next cycle flush_o = 1 for one cycle and redirect_pc_o = 0x2000.
- BGE at pc 0x40, pred=1, less=1 -> flush next cycle, redirect_pc_o = 0x44. Same case with pc 0xFFFFFFFC -> redirect_pc_o = 0.
- Valid branch held in the flush cycle, and funct3 = 010 -> no BHT change and no flush; illegal pulses only for the 010 case.
- Update at index 5 while pc_f_i maps to index 5 -> same-cycle prediction shows the old value and the next cycle shows the new one. Assert rst_i mid-flush -> all outputs are 0 asynchronously.
- With BRU_PERF_CNT_EN defined, 10 branches with 3 mispredicts -> br_cnt_o = 10 and mispred_cnt_o = 3. Preload br_cnt_o to 0xFFFFFFFF and resolve one branch -> wraps to 0.
